// File: rtl/dsp_shot_sequencer.sv
// Shot sequencer between the DSP register bank and the DSP core.
// Runs a burst of shots at a fixed period, collects per-channel done, and flags overruns.
module dsp_shot_sequencer #(
  parameter int NSHOTWIDTH  = 16,
  parameter int PERIODWIDTH = 24,
  parameter int NCH         = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   stb_start,
  input  logic                   stb_abort,
  input  logic [NSHOTWIDTH-1:0]  nshot,
  input  logic [PERIODWIDTH-1:0] period,
  input  logic                   resetacc,
  input  logic [NCH-1:0]         chan_mask,
  input  logic [NCH-1:0]         chan_done,
  output logic                   shot_stb,
  output logic                   acc_reset,
  output logic                   busy,
  output logic [NSHOTWIDTH-1:0]  shotcnt,
  output logic                   lastshotdone,
  output logic                   overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ACCRST, S_SHOT, S_WAIT} state_t;

  state_t                  state_q;
  logic [NSHOTWIDTH-1:0]   nshot_q;
  logic [NSHOTWIDTH-1:0]   shotcnt_q;
  logic [NSHOTWIDTH-1:0]   shotcnt_d;
  logic [PERIODWIDTH-1:0]  period_q;
  logic [PERIODWIDTH-1:0]  cnt_q;
  logic [PERIODWIDTH-1:0]  cnt_ld_d;
  logic [NCH-1:0]          mask_q;
  logic [NCH-1:0]          collect_q;
  logic [NCH-1:0]          mask_hit;
  logic                    counted_q;
  logic                    lastdone_q;
  logic                    overrun_q;
  logic                    complete;
  logic                    first_complete;

  assign mask_hit       = chan_done & mask_q;
  assign complete       = ((collect_q | mask_hit) == mask_q);
  assign first_complete = complete && !counted_q;
  assign shotcnt_d      = shotcnt_q + {{(NSHOTWIDTH-1){1'b0}}, first_complete};
  // Periods below 2 are clamped so a shot always spans SHOT plus at least one WAIT cycle.
  assign cnt_ld_d       = (period_q < PERIODWIDTH'(2)) ? '0 : period_q - PERIODWIDTH'(2);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      nshot_q    <= '0;
      shotcnt_q  <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      collect_q  <= '0;
      counted_q  <= 1'b0;
      lastdone_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (stb_abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stb_start && !stb_abort) begin
            nshot_q   <= nshot;
            period_q  <= period;
            mask_q    <= chan_mask;
            shotcnt_q <= '0;
            overrun_q <= 1'b0;
            if (nshot == '0) begin
              lastdone_q <= 1'b1;
            end else begin
              lastdone_q <= 1'b0;
              state_q    <= resetacc ? S_ACCRST : S_SHOT;
            end
          end
        end
        S_ACCRST: state_q <= S_SHOT;
        S_SHOT: begin
          cnt_q     <= cnt_ld_d;
          collect_q <= mask_hit;
          counted_q <= 1'b0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          collect_q <= collect_q | mask_hit;
          if (cnt_q != '0) cnt_q <= cnt_q - PERIODWIDTH'(1);
          if (first_complete) begin
            shotcnt_q <= shotcnt_d;
            counted_q <= 1'b1;
          end
          // Completion and period expiry must both hold before the next shot or the end of run.
          if (cnt_q == '0) begin
            if (!complete) begin
              overrun_q <= 1'b1;
            end else if (shotcnt_d == nshot_q) begin
              lastdone_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              state_q <= S_SHOT;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign shot_stb     = (state_q == S_SHOT);
  assign acc_reset    = (state_q == S_ACCRST);
  assign busy         = (state_q != S_IDLE);
  assign shotcnt      = shotcnt_q;
  assign lastshotdone = lastdone_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dsp_shot_sequencer.sv
// Bench for dsp_shot_sequencer: timeline model of shot/done/period rules, checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.
module tb_dsp_shot_sequencer;
  localparam int NW = 16;
  localparam int PW = 24;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          stb_start;
  logic          stb_abort;
  logic [NW-1:0] nshot;
  logic [PW-1:0] period;
  logic          resetacc;
  logic [NC-1:0] chan_mask;
  logic [NC-1:0] chan_done;
  logic          shot_stb;
  logic          acc_reset;
  logic          busy;
  logic [NW-1:0] shotcnt;
  logic          lastshotdone;
  logic          overrun;

  dsp_shot_sequencer #(.NSHOTWIDTH(NW), .PERIODWIDTH(PW), .NCH(NC)) dut (
    .clk(clk), .aresetn(aresetn), .stb_start(stb_start), .stb_abort(stb_abort),
    .nshot(nshot), .period(period), .resetacc(resetacc), .chan_mask(chan_mask),
    .chan_done(chan_done), .shot_stb(shot_stb), .acc_reset(acc_reset), .busy(busy),
    .shotcnt(shotcnt), .lastshotdone(lastshotdone), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s     = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  // Timeline model: shot at T; completion cycle C is the first cycle after T by which every
  // masked done (presented from T on) has been seen; next shot or end at max(T+P, C+1).
  bit            m_act = 1'b0;
  bit            m_ld  = 1'b0;
  bit            m_ov  = 1'b0;
  int            m_T   = -1;
  int            m_acc = -1;
  int            m_C   = -1;
  int            m_P   = 2;
  int            m_n   = 0;
  int            m_cnt = 0;
  logic [NC-1:0] m_mask = '0;
  logic [NC-1:0] m_col  = '0;

  always @(posedge clk) begin
    int prev;
    int pp;
    cyc++;
    prev = cyc - 1;
    if (!aresetn) begin
      m_act = 1'b0; m_ld = 1'b0; m_ov = 1'b0; m_cnt = 0;
      m_T = -1; m_acc = -1; m_C = -1;
    end else if (m_act) begin
      if (stb_abort) begin
        m_act = 1'b0;
      end else begin
        if (prev >= m_T && m_C < 0) begin
          m_col = m_col | (chan_done & m_mask);
          if (prev > m_T && m_col == m_mask) begin
            m_C = prev;
            m_cnt++;
          end
        end
        if (m_C < 0 && cyc == m_T + m_P) m_ov = 1'b1;
        if (m_C >= 0 && cyc >= m_T + m_P && cyc >= m_C + 1) begin
          if (m_cnt == m_n) begin
            m_act = 1'b0;
            m_ld  = 1'b1;
          end else begin
            m_T   = cyc;
            m_col = '0;
            m_C   = -1;
          end
        end
      end
    end else if (stb_start && !stb_abort) begin
      pp     = 32'(period);
      m_P    = (pp < 2) ? 2 : pp;
      m_n    = 32'(nshot);
      m_mask = chan_mask;
      m_cnt  = 0;
      m_ov   = 1'b0;
      m_C    = -1;
      m_col  = '0;
      if (m_n == 0) begin
        m_ld = 1'b1;
      end else begin
        m_ld  = 1'b0;
        m_act = 1'b1;
        m_acc = resetacc ? cyc : -1;
        m_T   = resetacc ? cyc + 1 : cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!aresetn) begin
        chk("rst_shot_stb", 32'(shot_stb), 32'd0);
        chk("rst_acc_reset", 32'(acc_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shotcnt", 32'(shotcnt), 32'd0);
        chk("rst_lastshotdone", 32'(lastshotdone), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
      end else begin
        chk("m_shot_stb", 32'(shot_stb), 32'(m_act && cyc == m_T));
        chk("m_acc_reset", 32'(acc_reset), 32'(m_act && cyc == m_acc));
        chk("m_busy", 32'(busy), 32'(m_act));
        chk("m_shotcnt", 32'(shotcnt), 32'(m_cnt));
        chk("m_lastshotdone", 32'(lastshotdone), 32'(m_ld));
        chk("m_overrun", 32'(overrun), 32'(m_ov));
      end
    end
  end

  // Readout responder: pulse resp_bits resp_delay cycles after each observed shot_stb.
  bit            resp_en    = 1'b0;
  int            resp_delay = 1;
  logic [NC-1:0] resp_bits  = '0;
  int            cd         = 0;

  always @(posedge clk) begin
    #1;
    chan_done = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) chan_done = resp_bits;
    end
    if (resp_en && shot_stb) cd = resp_delay;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_cycle(input int x);
    while (cyc < x) tick();
  endtask

  task automatic at_cycle(input int x);
    go_cycle(x);
    @(negedge clk);
  endtask

  task automatic start_run(input int n, input int p, input bit ra, input logic [NC-1:0] m,
                           input bit ab);
    tick();
    s         = cyc;
    stb_start = 1'b1;
    stb_abort = ab;
    nshot     = NW'(n);
    period    = PW'(p);
    resetacc  = ra;
    chan_mask = m;
    tick();
    stb_start = 1'b0;
    stb_abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; stb_start = 1'b0; stb_abort = 1'b0;
    nshot = '0; period = '0; resetacc = 1'b0; chan_mask = '0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_shotcnt", 32'(shotcnt), 32'd0);
    chk("reset_lastshotdone", 32'(lastshotdone), 32'd0);
    chk("reset_shot_stb", 32'(shot_stb), 32'd0);
    tick(); tick();
    aresetn = 1'b1;
    cmp_en  = 1'b1;
    tick(); tick();

    // Nominal with accumulator reset, plus an ignored start mid-run.
    resp_en = 1'b1; resp_delay = 4; resp_bits = 4'b0011;
    start_run(3, 10, 1'b1, 4'b0011, 1'b0);
    at_cycle(s + 1);  chk("nom_acc_s1", 32'(acc_reset), 32'd1); chk("nom_busy_s1", 32'(busy), 32'd1);
    at_cycle(s + 2);  chk("nom_shot_s2", 32'(shot_stb), 32'd1); chk("nom_acc_s2", 32'(acc_reset), 32'd0);
    at_cycle(s + 7);  chk("nom_cnt_s7", 32'(shotcnt), 32'd1);
    at_cycle(s + 12); chk("nom_shot_s12", 32'(shot_stb), 32'd1);
    go_cycle(s + 15);
    stb_start = 1'b1; nshot = NW'(9); resetacc = 1'b0;
    tick();
    stb_start = 1'b0;
    at_cycle(s + 17); chk("nom_cnt_s17", 32'(shotcnt), 32'd2);
    at_cycle(s + 22); chk("nom_shot_s22", 32'(shot_stb), 32'd1);
    at_cycle(s + 27); chk("nom_cnt_s27", 32'(shotcnt), 32'd3);
    at_cycle(s + 31); chk("nom_busy_s31", 32'(busy), 32'd1);
    at_cycle(s + 32); chk("nom_busy_s32", 32'(busy), 32'd0);
    chk("nom_last_s32", 32'(lastshotdone), 32'd1); chk("nom_ovr_s32", 32'(overrun), 32'd0);
    go_cycle(cyc + 3);

    // Overrun: period 4, done arrives 7 cycles after each shot.
    resp_delay = 7; resp_bits = 4'b0001;
    start_run(2, 4, 1'b0, 4'b0001, 1'b0);
    at_cycle(s + 1);  chk("ovr_shot_s1", 32'(shot_stb), 32'd1);
    at_cycle(s + 4);  chk("ovr_ovr_s4", 32'(overrun), 32'd0);
    at_cycle(s + 5);  chk("ovr_ovr_s5", 32'(overrun), 32'd1);
    at_cycle(s + 9);  chk("ovr_shot_s9", 32'(shot_stb), 32'd1); chk("ovr_cnt_s9", 32'(shotcnt), 32'd1);
    at_cycle(s + 17); chk("ovr_last_s17", 32'(lastshotdone), 32'd1);
    chk("ovr_busy_s17", 32'(busy), 32'd0); chk("ovr_cnt_s17", 32'(shotcnt), 32'd2);
    at_cycle(s + 20); chk("ovr_sticky_s20", 32'(overrun), 32'd1);

    // Zero shots: clears overrun, raises lastshotdone without a run.
    start_run(0, 5, 1'b1, 4'b0001, 1'b0);
    at_cycle(s + 1);  chk("zero_last_s1", 32'(lastshotdone), 32'd1);
    chk("zero_busy_s1", 32'(busy), 32'd0); chk("zero_ovr_s1", 32'(overrun), 32'd0);
    chk("zero_acc_s1", 32'(acc_reset), 32'd0);
    at_cycle(s + 2);  chk("zero_shot_s2", 32'(shot_stb), 32'd0);
    go_cycle(cyc + 2);

    // Clamp: period 1 with empty mask gives shots every 2 cycles.
    resp_en = 1'b0;
    start_run(4, 1, 1'b0, 4'b0000, 1'b0);
    at_cycle(s + 1);  chk("clamp_shot_s1", 32'(shot_stb), 32'd1);
    at_cycle(s + 2);  chk("clamp_shot_s2", 32'(shot_stb), 32'd0);
    at_cycle(s + 3);  chk("clamp_shot_s3", 32'(shot_stb), 32'd1); chk("clamp_cnt_s3", 32'(shotcnt), 32'd1);
    at_cycle(s + 7);  chk("clamp_shot_s7", 32'(shot_stb), 32'd1);
    at_cycle(s + 9);  chk("clamp_cnt_s9", 32'(shotcnt), 32'd4);
    chk("clamp_last_s9", 32'(lastshotdone), 32'd1); chk("clamp_busy_s9", 32'(busy), 32'd0);
    go_cycle(cyc + 2);

    // Abort after the second shot completes; unmasked done bits are ignored.
    resp_en = 1'b1; resp_delay = 2; resp_bits = 4'b1100;
    start_run(5, 6, 1'b0, 4'b0100, 1'b0);
    at_cycle(s + 10); chk("abt_cnt_s10", 32'(shotcnt), 32'd2); chk("abt_busy_s10", 32'(busy), 32'd1);
    stb_abort = 1'b1;
    tick();
    stb_abort = 1'b0;
    at_cycle(s + 11); chk("abt_busy_s11", 32'(busy), 32'd0);
    chk("abt_cnt_s11", 32'(shotcnt), 32'd2); chk("abt_last_s11", 32'(lastshotdone), 32'd0);
    at_cycle(s + 14); chk("abt_shot_s14", 32'(shot_stb), 32'd0); chk("abt_cnt_s14", 32'(shotcnt), 32'd2);

    // Start and abort together in IDLE: no run, nothing cleared.
    start_run(3, 4, 1'b1, 4'b0001, 1'b1);
    at_cycle(s + 1);  chk("sa_busy_s1", 32'(busy), 32'd0); chk("sa_cnt_s1", 32'(shotcnt), 32'd2);
    chk("sa_acc_s1", 32'(acc_reset), 32'd0);
    at_cycle(s + 3);  chk("sa_busy_s3", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    resp_delay = 20; resp_bits = 4'b0001;
    start_run(3, 8, 1'b0, 4'b0001, 1'b0);
    at_cycle(s + 3);  chk("ar_busy_s3", 32'(busy), 32'd1);
    go_cycle(s + 4);
    aresetn = 1'b0;
    @(negedge clk);
    chk("ar_busy_now", 32'(busy), 32'd0);
    tick();
    aresetn = 1'b1;
    go_cycle(cyc + 25);

    // Single shot after reset recovery.
    resp_delay = 1; resp_bits = 4'b0001;
    start_run(1, 3, 1'b0, 4'b0001, 1'b0);
    at_cycle(s + 3);  chk("one_cnt_s3", 32'(shotcnt), 32'd1); chk("one_busy_s3", 32'(busy), 32'd1);
    at_cycle(s + 4);  chk("one_last_s4", 32'(lastshotdone), 32'd1); chk("one_busy_s4", 32'(busy), 32'd0);
    go_cycle(cyc + 3);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
